sparse_kv_store: RTL and testbench

- Next-generation CSR-style sparse store holding up to MAX_VALUES (index, value) pairs.
- Uses a valid/ready command and response handshake and a multi-cycle search FSM that scans LANES entries per cycle.
- Supports read, write with update-in-place, delete-on-zero and clear.
- Sits between the sparse weight loader and the compute datapath as a scratch store for sparse vectors.

---
 rtl/sparse_kv_store.sv | 199 +++++++++++++++++++
 tb/tb_sparse_kv_store.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_kv_store.sv
// Sparse (index, value) store with a multi-cycle LANES-wide search FSM and valid/ready handshakes.
// Optional hit/miss statistics counters are enabled with `define SPARSE_STATS_EN.
module sparse_kv_store #(
  parameter int MAX_VALUES  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 8,
  parameter int LANES       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [INDEX_WIDTH-1:0]        cmd_idx,
  input  logic [DATA_WIDTH-1:0]         cmd_val,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_hit,
  output logic                          rsp_err,
  output logic [$clog2(MAX_VALUES):0]   num_stored,
  output logic                          full,
  output logic                          empty
`ifdef SPARSE_STATS_EN
  ,
  output logic [15:0]                   stat_hits,
  output logic [15:0]                   stat_misses
`endif
);

  localparam int SLOT_W  = $clog2(MAX_VALUES);
  localparam int CW      = SLOT_W + 1;
  localparam int CHUNKS  = MAX_VALUES / LANES;
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, UPDATE, RESP} state_t;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_CLEAR = 2'b10} op_t;

  state_t                 state;
  op_t                    op_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0]  val_q;
  logic [CHUNK_W-1:0]     chunk;
  logic                   hit_q;
  logic [SLOT_W-1:0]      slot_q;
  logic [DATA_WIDTH-1:0]  old_q;

  logic [INDEX_WIDTH-1:0] idx_mem [MAX_VALUES];
  logic [DATA_WIDTH-1:0]  val_mem [MAX_VALUES];

  logic                   found;
  logic [SLOT_W-1:0]      found_slot;
  logic [SLOT_W-1:0]      slot_c;
  logic                   last_chunk;

  // NOTE: every variable driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    found      = 1'b0;
    found_slot = '0;
    slot_c     = '0;
    // Walk lanes high to low so the lowest matching slot is the one left standing.
    for (int j = LANES - 1; j >= 0; j--) begin
      slot_c = SLOT_W'(int'(chunk) * LANES + j);
      if (({1'b0, slot_c} < num_stored) && (idx_mem[slot_c] == idx_q)) begin
        found      = 1'b1;
        found_slot = slot_c;
      end
    end
    last_chunk = ((int'(chunk) + 1) * LANES) >= int'(num_stored);
  end

  logic                   mem_we;
  logic [SLOT_W-1:0]      mem_addr;
  logic [SLOT_W-1:0]      last_slot;
  logic [INDEX_WIDTH-1:0] mem_idx;
  logic [DATA_WIDTH-1:0]  mem_val;
  logic [CW-1:0]          num_next;
  logic                   err_next;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = slot_q;
    mem_idx   = idx_q;
    mem_val   = val_q;
    num_next  = num_stored;
    err_next  = 1'b0;
    last_slot = SLOT_W'(num_stored - 1'b1);
    if (state == UPDATE) begin
      case (op_q)
        OP_WRITE: begin
          if (hit_q) begin
            mem_we = 1'b1;
            if (val_q == '0) begin
              // Delete: the last live entry fills the hole (a self-copy when the hole is last).
              mem_idx  = idx_mem[last_slot];
              mem_val  = val_mem[last_slot];
              num_next = num_stored - 1'b1;
            end
          end else if (val_q != '0) begin
            if (full) begin
              err_next = 1'b1;
            end else begin
              mem_we   = 1'b1;
              mem_addr = SLOT_W'(num_stored);
              num_next = num_stored + 1'b1;
            end
          end
        end
        OP_CLEAR: num_next = '0;
        default:  ;
      endcase
    end
  end

  // NOTE: slot storage has no reset; num_stored alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      idx_mem[mem_addr] <= mem_idx;
      val_mem[mem_addr] <= mem_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_READ;
      idx_q      <= '0;
      val_q      <= '0;
      chunk      <= '0;
      hit_q      <= 1'b0;
      slot_q     <= '0;
      old_q      <= '0;
      num_stored <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_hit    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op_q  <= (cmd_op == 2'b01) ? OP_WRITE : (cmd_op == 2'b10) ? OP_CLEAR : OP_READ;
          idx_q <= cmd_idx;
          val_q <= cmd_val;
          chunk <= '0;
          hit_q <= 1'b0;
          state <= (cmd_op == 2'b10) ? UPDATE : SEARCH;
        end
        SEARCH: begin
          if (found) begin
            hit_q  <= 1'b1;
            slot_q <= found_slot;
            old_q  <= val_mem[found_slot];
            state  <= UPDATE;
          end else if (last_chunk) begin
            state <= UPDATE;
          end else begin
            chunk <= chunk + 1'b1;
          end
        end
        UPDATE: begin
          num_stored <= num_next;
          rsp_valid  <= 1'b1;
          rsp_hit    <= hit_q;
          rsp_data   <= hit_q ? old_q : '0;
          rsp_err    <= err_next;
          state      <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPARSE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == UPDATE) begin
      if (op_q == OP_CLEAR) begin
        stat_hits   <= '0;
        stat_misses <= '0;
      end else if (hit_q) begin
        if (stat_hits != 16'hffff) stat_hits <= stat_hits + 16'd1;
      end else begin
        if (stat_misses != 16'hffff) stat_misses <= stat_misses + 16'd1;
      end
    end
  end
`endif

  assign cmd_ready = (state == IDLE);
  assign full      = (num_stored == CW'(MAX_VALUES));
  assign empty     = (num_stored == '0);

endmodule

// File: tb/tb_sparse_kv_store.sv
// Self-checking bench for sparse_kv_store: directed scenarios plus random traffic against a queue model.
// Honours SPARSE_STATS_EN when the design is built with it.
module tb_sparse_kv_store;

  localparam int MAXV  = 16;
  localparam int DW    = 8;
  localparam int IW    = 8;
  localparam int LANES = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [IW-1:0] cmd_idx = '0;
  logic [DW-1:0] cmd_val = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_hit;
  logic          rsp_err;
  logic [4:0]    num_stored;
  logic          full;
  logic          empty;
`ifdef SPARSE_STATS_EN
  logic [15:0]   stat_hits;
  logic [15:0]   stat_misses;
`endif

  sparse_kv_store #(.MAX_VALUES(MAXV), .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_val(cmd_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .num_stored(num_stored), .full(full), .empty(empty)
`ifdef SPARSE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: live entries in slot order, plus hit/miss tallies.
  int m_idx[$];
  int m_val[$];
  int m_hits   = 0;
  int m_misses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic end_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic int m_find(input int idx);
    for (int i = 0; i < m_idx.size(); i++) if (m_idx[i] == idx) return i;
    return -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_hit"}, rsp_hit, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_num"}, num_stored, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
`ifdef SPARSE_STATS_EN
    check({tag, "_hits"}, stat_hits, 0);
    check({tag, "_misses"}, stat_misses, 0);
`endif
  endtask

  // Issues one command; hold > 0 keeps rsp_ready low for that many cycles once the response appears.
  task automatic do_cmd(input int op, input int idx, input int val, input int hold);
    int pos, n, s, lat, lat_lo, lat_hi, e_data, e_hit, e_err;
    n = m_idx.size();
    pos = (op == 2) ? -1 : m_find(idx);
    e_data = 0; e_hit = 0; e_err = 0;
    if (op == 2) begin
      lat_lo = 2; lat_hi = 2;
      m_idx.delete(); m_val.delete();
      m_hits = 0; m_misses = 0;
    end else begin
      s = (n == 0) ? 1 : (n + LANES - 1) / LANES;
      lat_hi = s + 2;
      lat_lo = (pos >= 0) ? pos / LANES + 3 : s + 2;
      if (pos >= 0) begin
        e_hit = 1; e_data = m_val[pos];
        if (m_hits < 65535) m_hits++;
      end else if (m_misses < 65535) begin
        m_misses++;
      end
      if (op == 1) begin
        if (pos >= 0) begin
          if (val != 0) m_val[pos] = val;
          else begin
            m_idx[pos] = m_idx[n-1]; m_val[pos] = m_val[n-1];
            void'(m_idx.pop_back()); void'(m_val.pop_back());
          end
        end else if (val != 0) begin
          if (n == MAXV) e_err = 1;
          else begin m_idx.push_back(idx); m_val.push_back(val); end
        end
      end
    end

    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op[1:0]; cmd_idx = idx[IW-1:0]; cmd_val = val[DW-1:0];
    rsp_ready = (hold == 0);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        cmd_valid = 1'b0;
        check("cmd_ready_busy", cmd_ready, 0);
      end
      if (lat > 40) begin
        check("rsp_timeout", rsp_valid, 1);
        end_run();
      end
    end while (!rsp_valid);

    if (lat_lo == lat_hi) check("latency", lat, lat_lo);
    else check("latency_in_range", (lat >= lat_lo) && (lat <= lat_hi), 1);
    check("rsp_data", rsp_data, e_data);
    check("rsp_hit", rsp_hit, e_hit);
    check("rsp_err", rsp_err, e_err);
    check("num_stored", num_stored, m_idx.size());
    check("full", full, m_idx.size() == MAXV);
    check("empty", empty, m_idx.size() == 0);
`ifdef SPARSE_STATS_EN
    check("stat_hits", stat_hits, m_hits);
    check("stat_misses", stat_misses, m_misses);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, e_data);
      check("stall_hit", rsp_hit, e_hit);
      check("stall_err", rsp_err, e_err);
      check("stall_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    int op, idx, val;
    #12;
    check_idle_outputs("in_reset");
    check("in_reset_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Empty read, then basic writes/read.
    do_cmd(0, 5, 0, 0);
    do_cmd(1, 3, 'h11, 0);
    do_cmd(1, 7, 'h22, 0);
    do_cmd(1, 9, 'h33, 0);
    do_cmd(0, 7, 0, 0);
    // Update in place, delete, and delete-miss.
    do_cmd(1, 7, 'h55, 0);
    do_cmd(0, 7, 0, 0);
    do_cmd(1, 3, 0, 0);
    do_cmd(0, 9, 0, 0);
    do_cmd(0, 3, 0, 0);
    do_cmd(1, 42, 0, 0);
    do_cmd(3, 9, 0, 0);

    // Fill to capacity, overflow, read the last slot, stall the response.
    do_cmd(2, 0, 0, 0);
    for (int i = 0; i < MAXV; i++) do_cmd(1, 100 + i, i + 1, 0);
    do_cmd(1, 200, 1, 0);
    do_cmd(0, 100 + MAXV - 1, 0, 0);
    do_cmd(0, 100, 0, 5);
    do_cmd(1, 100, 0, 0);
    do_cmd(0, 100 + MAXV - 1, 0, 0);

    // Reset while a full-length miss search is in flight.
    do_cmd(1, 201, 7, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_idx = 8'd250; cmd_val = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("search_busy", cmd_ready, 0);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    check("mid_reset_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    m_idx.delete(); m_val.delete(); m_hits = 0; m_misses = 0;
    do_cmd(0, 5, 0, 0);

    // Random traffic over a small index range so hits, deletes and overflow all occur.
    for (int k = 0; k < 250; k++) begin
      op  = ($urandom_range(0, 39) == 0) ? 2 : ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 1);
      idx = $urandom_range(0, 23);
      val = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
      do_cmd(op, idx, val, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
    end

    end_run();
  end

endmodule
